// File: rtl/instruction_step_sequencer.sv
// Control-step counter for the SAP-style controller.
// Tracks the microcode step of the executing instruction. It supports variable
// instruction length, a fetch-phase flag, sticky halt with explicit resume, and
// a retire pulse.
// Optional: define SEQ_RETIRE_COUNT_EN to build the retired-instruction
// counter. Without it, o_retired is tied to 0.
module instruction_step_sequencer #(
  parameter int INSTRUCTION_STEPS = 8,
  parameter int FETCH_STEPS       = 2,
  parameter int COUNT_WIDTH       = 16,
  localparam int STEP_WIDTH = (INSTRUCTION_STEPS > 2) ? $clog2(INSTRUCTION_STEPS) : 1,
  localparam int LEN_WIDTH  = $clog2(INSTRUCTION_STEPS + 1)
) (
  input  logic                   mclk,
  input  logic                   i_rst,
  input  logic                   mclk_en,
  input  logic                   i_halt,
  input  logic                   i_resume,
  input  logic                   i_adv,
  input  logic [LEN_WIDTH-1:0]   i_step_len,
  output logic [STEP_WIDTH-1:0]  o_step,
  output logic                   o_fetch,
  output logic                   o_last,
  output logic                   o_halted,
  output logic                   o_retire,
  output logic [COUNT_WIDTH-1:0] o_retired
);

  localparam logic [LEN_WIDTH-1:0]  MAX_LEN   = LEN_WIDTH'(INSTRUCTION_STEPS);
  localparam logic [LEN_WIDTH-1:0]  MIN_LEN   = LEN_WIDTH'(FETCH_STEPS + 1);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1);
  localparam logic [STEP_WIDTH-1:0] STEP_ONE  = STEP_WIDTH'(1);
  localparam logic [STEP_WIDTH-1:0] FETCH_END = STEP_WIDTH'(FETCH_STEPS);

  typedef enum logic [0:0] {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t                state_q, state_n;
  logic [STEP_WIDTH-1:0] step_q, step_n;
  logic                  retire_q, retire_n;
  logic [LEN_WIDTH-1:0]  eff_len;
  logic                  in_fetch;
  logic                  wrap;

  assign in_fetch = (step_q < FETCH_END);

  // Effective instruction length. The opcode is not valid during fetch, so the
  // full length is used there. Otherwise the ROM length is clamped to a legal range.
  always_comb begin
    eff_len = i_step_len;
    if (in_fetch)                eff_len = MAX_LEN;
    else if (i_step_len < MIN_LEN) eff_len = MIN_LEN;
    else if (i_step_len > MAX_LEN) eff_len = MAX_LEN;
  end

  assign o_last   = (state_q == RUN) && (LEN_WIDTH'(step_q) == (eff_len - LEN_ONE));
  assign wrap     = i_adv | o_last;
  assign o_step   = step_q;
  assign o_halted = (state_q == HALTED);
  assign o_fetch  = in_fetch & (state_q != HALTED);
  assign o_retire = retire_q;

  // Next state, step and retire. A disabled edge holds the state and clears retire.
  // Resume only re-enters RUN; the step moves on the following enabled edge.
  always_comb begin
    state_n  = state_q;
    step_n   = step_q;
    retire_n = 1'b0;
    if (mclk_en) begin
      unique case (state_q)
        RUN: begin
          if (i_halt) begin
            state_n = HALTED;
          end else begin
            step_n   = wrap ? '0 : step_q + STEP_ONE;
            // An aborted fetch restarts without retiring anything.
            retire_n = wrap & ~in_fetch;
          end
        end
        HALTED: begin
          if (i_resume) state_n = RUN;
        end
        default: state_n = RUN;
      endcase
    end
  end

  // State registers with synchronous reset. Reset takes priority over the clock enable.
  always_ff @(posedge mclk) begin
    if (i_rst) begin
      state_q  <= RUN;
      step_q   <= '0;
      retire_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      step_q   <= step_n;
      retire_q <= retire_n;
    end
  end

`ifdef SEQ_RETIRE_COUNT_EN
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);
  logic [COUNT_WIDTH-1:0] retired_q;

  // Retired-instruction count. It increments on the same edge that raises o_retire
  // and wraps naturally.
  always_ff @(posedge mclk) begin
    if (i_rst)         retired_q <= '0;
    else if (retire_n) retired_q <= retired_q + CNT_ONE;
  end

  assign o_retired = retired_q;
`else
  assign o_retired = '0;
`endif

endmodule
